// File: rtl/tff_pkg.sv
// -----------------------------------------------------------------------------
// tff_pkg
// Shared definitions for the T flip-flop bank: the operating-mode encoding
// used by tff_bank and by anything that drives its mode input.
// -----------------------------------------------------------------------------
package tff_pkg;

  localparam int MODE_W = 2;

  // Operating mode of the bank. The enumerators double as the mode constants.
  typedef enum logic [MODE_W-1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } tff_mode_e;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// -----------------------------------------------------------------------------
// tff_cell
// Single T flip-flop with parallel load. State changes on the falling edge
// of clk. Priority: rst low > ld > tog > hold.
//
// Ports
//   clk  in   clock (falling-edge active)
//   rst  in   synchronous reset, active-low
//   tog  in   toggle request
//   ld   in   load request (overrides tog)
//   d    in   load data
//   q    out  cell state (registered)
// -----------------------------------------------------------------------------
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic tog,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next-state selection: load beats toggle, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (tog) begin
      q_d = ~q_q;
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous active-low reset on the falling edge.
  always_ff @(negedge clk) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : tff_cell

// File: rtl/tff_bank.sv
// -----------------------------------------------------------------------------
// tff_bank
// Bank of WIDTH T flip-flops that can toggle independently, count up or down
// as a synchronous T-cascade, or take a parallel load. All state updates on
// the falling edge of clk.
//
// Build option
//   TFF_BANK_SAT_EN  when defined, UP/DOWN saturate at all-ones / zero instead
//                    of rolling over; tc still asserts and wrap never rises.
//
// Parameters
//   WIDTH  number of cells, must be >= 2
//
// Ports
//   clk   in   clock (falling-edge active)
//   rst   in   synchronous reset, active-low
//   en    in   enable for TOGGLE/UP/DOWN (ignored by LOAD)
//   mode  in   00 TOGGLE, 01 UP, 10 DOWN, 11 LOAD
//   t     in   per-bit toggle requests (TOGGLE mode only)
//   d     in   parallel load data
//   q     out  cell state (registered)
//   qbar  out  ~q (combinational)
//   tc    out  terminal count (combinational from q, mode, en)
//   wrap  out  one-cycle registered pulse on rollover
// -----------------------------------------------------------------------------
module tff_bank
  import tff_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  tff_mode_e        mode_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] ones_pre_s;   // bit i: all of q[i-1:0] are 1
  logic [WIDTH-1:0] zeros_pre_s;  // bit i: all of q[i-1:0] are 0
  logic [WIDTH-1:0] tog_raw_s;
  logic [WIDTH-1:0] tog_s;
  logic             ld_s;
  logic             tc_s;
  logic             wrap_d;
  logic             wrap_q;

  assign mode_s = tff_mode_e'(mode);
  assign ld_s   = (mode_s == MODE_LOAD);

  // Prefix AND of lower bits, which is the T-cascade carry/borrow chain.
  // A running accumulator keeps the chain free of vector self-reference.
  always_comb begin
    logic acc_ones;
    logic acc_zeros;
    acc_ones    = 1'b1;
    acc_zeros   = 1'b1;
    ones_pre_s  = '0;
    zeros_pre_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_pre_s[i]  = acc_ones;
      zeros_pre_s[i] = acc_zeros;
      acc_ones       = acc_ones & q_s[i];
      acc_zeros      = acc_zeros & ~q_s[i];
    end
  end

  // Terminal count: counter sits at its rollover value in an enabled count mode.
  always_comb begin
    tc_s = 1'b0;
    if (en) begin
      case (mode_s)
        MODE_UP:     tc_s = &q_s;
        MODE_DOWN:   tc_s = ~(|q_s);
        MODE_TOGGLE: tc_s = 1'b0;
        MODE_LOAD:   tc_s = 1'b0;
        default:     tc_s = 1'b0;
      endcase
    end else begin
      tc_s = 1'b0;
    end
  end

  // Per-cell toggle enables for the enabled non-load modes.
  always_comb begin
    tog_raw_s = '0;
    if (en) begin
      case (mode_s)
        MODE_TOGGLE: tog_raw_s = t;
        MODE_UP:     tog_raw_s = ones_pre_s;
        MODE_DOWN:   tog_raw_s = zeros_pre_s;
        MODE_LOAD:   tog_raw_s = '0;
        default:     tog_raw_s = '0;
      endcase
    end else begin
      tog_raw_s = '0;
    end
  end

`ifdef TFF_BANK_SAT_EN
  // At the terminal count the cascade would roll over, so freeze it instead.
  assign tog_s = tc_s ? '0 : tog_raw_s;
`else
  assign tog_s = tog_raw_s;
`endif

  // Rollover pulse: follows tc unless this edge is a load.
  always_comb begin
    wrap_d = 1'b0;
    if (ld_s) begin
      wrap_d = 1'b0;
    end else begin
`ifdef TFF_BANK_SAT_EN
      wrap_d = 1'b0;
`else
      wrap_d = tc_s;
`endif
    end
  end

  // Rollover pulse register, cleared by reset.
  always_ff @(negedge clk) begin
    if (!rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .tog (tog_s[i]),
      .ld  (ld_s),
      .d   (d[i]),
      .q   (q_s[i])
    );
  end

  assign q    = q_s;
  assign qbar = ~q_s;
  assign tc   = tc_s;
  assign wrap = wrap_q;

endmodule : tff_bank
